// File: rtl/freq_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package freq_pkg;

    localparam int CW_DEFAULT = 19;
    localparam int DIV_1HZ    = 499999;

    typedef logic [CW_DEFAULT-1:0] cnt_t;
    typedef logic [CW_DEFAULT-1:0] div_t;

    // Channel-index width; a single channel still gets a one-bit index.
    function automatic int chidx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/freq_div_multi_ch.sv
// One divider channel: counter, active/shadow divisor, pending flag, square wave and tick.
module freq_div_multi_ch
    import freq_pkg::*;
#(
    parameter int CW          = CW_DEFAULT,
    parameter int DIV_DEFAULT = DIV_1HZ
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    output logic          clk_out,
    output logic          tick,
    output logic          pend
);

    localparam logic [CW-1:0] DIV_INIT = CW'(DIV_DEFAULT);

    logic [CW-1:0] cnt_r, cnt_s;
    logic [CW-1:0] div_r, div_s;
    logic [CW-1:0] shadow_r, shadow_s;
    logic          pend_r, pend_s;
    logic          clk_r, clk_s;
    logic          tick_r, tick_s;

    // Next-state: sync restart, wrap/count, then the config write, which wins over a same-edge clear of pend.
    always_comb begin
        cnt_s    = cnt_r;
        div_s    = div_r;
        shadow_s = shadow_r;
        pend_s   = pend_r;
        clk_s    = clk_r;
        tick_s   = 1'b0;
        if (sync) begin
            cnt_s = {CW{1'b0}};
            clk_s = 1'b0;
            if (pend_r) begin
                div_s  = shadow_r;
                pend_s = 1'b0;
            end else begin
                div_s  = div_r;
            end
        end else if (en) begin
            // >= rather than == so an out-of-range count recovers on the next edge.
            if (cnt_r >= div_r) begin
                cnt_s  = {CW{1'b0}};
                clk_s  = ~clk_r;
                tick_s = 1'b1;
                if (pend_r) begin
                    div_s  = shadow_r;
                    pend_s = 1'b0;
                end else begin
                    div_s  = div_r;
                end
            end else begin
                cnt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
        if (wr) begin
            shadow_s = wr_div;
            pend_s   = 1'b1;
        end else begin
            shadow_s = shadow_s;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            div_r    <= DIV_INIT;
            shadow_r <= DIV_INIT;
            pend_r   <= 1'b0;
            clk_r    <= 1'b0;
            tick_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            div_r    <= div_s;
            shadow_r <= shadow_s;
            pend_r   <= pend_s;
            clk_r    <= clk_s;
            tick_r   <= tick_s;
        end
    end

    assign clk_out = clk_r;
    assign tick    = tick_r;
    assign pend    = pend_r;

endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock divider / tick generator top: write decode and channel array.
// Optional macro SYNC_RESTART_EN adds a 'sync' input that phase-aligns all channels.
module freq_div_multi
    import freq_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CW          = CW_DEFAULT,
    parameter int DIV_DEFAULT = DIV_1HZ
) (
    input  logic                      clk_in,
    input  logic                      rst,
`ifdef SYNC_RESTART_EN
    input  logic                      sync,
`endif
    input  logic [NCH-1:0]            en,
    input  logic                      cfg_we,
    input  logic [chidx_w(NCH)-1:0]   cfg_ch,
    input  logic [CW-1:0]             cfg_div,
    output logic [NCH-1:0]            cfg_pend,
    output logic [NCH-1:0]            clk_out,
    output logic [NCH-1:0]            tick
);

    localparam int CHW = chidx_w(NCH);

    logic           sync_s;
    logic [NCH-1:0] wr_s;

`ifdef SYNC_RESTART_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Out-of-range indices match no channel, so such writes are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_s[i] = cfg_we & (cfg_ch == CHW'(i));

        freq_div_multi_ch #(
            .CW          (CW),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .clk_in  (clk_in),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync_s),
            .wr      (wr_s[i]),
            .wr_div  (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (cfg_pend[i])
        );
    end

endmodule
